// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  // Operation encodings as presented by the execute stage; bit 1 selects divide and bit 0
  // selects signed.
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_e;

  // Acceptance-to-write latency of a full-length operation.
  localparam int unsigned DONE_LAT = 34;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation. In wide mode the whole 2*WIDTH value is negated
// under i_neg_hi. Otherwise the upper and lower halves are negated independently.
module muldiv_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_val,
  input  logic               i_wide,
  input  logic               i_neg_hi,
  input  logic               i_neg_lo,
  output logic [2*WIDTH-1:0] o_val
);

  logic [2*WIDTH-1:0] w_neg_wide;
  logic [WIDTH-1:0]   w_neg_hi;
  logic [WIDTH-1:0]   w_neg_lo;

  assign w_neg_wide = '0 - i_val;
  assign w_neg_hi   = '0 - i_val[2*WIDTH-1:WIDTH];
  assign w_neg_lo   = '0 - i_val[WIDTH-1:0];

  // Select the negated form of each part on request.
  always_comb begin
    o_val = i_val;
    if (i_wide) begin
      if (i_neg_hi) o_val = w_neg_wide;
    end else begin
      if (i_neg_hi) o_val[2*WIDTH-1:WIDTH] = w_neg_hi;
      if (i_neg_lo) o_val[WIDTH-1:0] = w_neg_lo;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide engine for the HI/LO register, one bit per cycle.
// Optional feature macro: MULDIV_EARLY_TERM_EN ends a multiply once the remaining multiplier
// bits are all zero.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_issue_valid,
  output logic             o_issue_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_hilo_rd_req,
  input  logic             i_flush,
  output logic             o_stall_req,
  output logic             o_we_hilo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div0,
  output logic             o_busy
);

  state_e             r_state, w_state_nxt;
  logic [1:0]         r_op;
  logic               r_neg_q;   // product / quotient is negated
  logic               r_neg_r;   // remainder is negated
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;     // product, or remainder in the low half
  logic [2*WIDTH-1:0] r_mcand;   // shifting multiplicand, or divisor in the low half
  logic [WIDTH-1:0]   r_mq;      // multiplier shifting out, or dividend -> quotient
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_div0;

  logic               w_accept, w_in_div, w_in_signed, w_is_div, w_b_zero, w_last, w_ge;
  logic [2*WIDTH-1:0] w_abs, w_fix_in, w_fixed, w_acc_mul;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_mq_mul, w_mq_div, w_rem_nxt;
  logic [WIDTH:0]     w_rem_sh, w_diff;

  assign w_in_div    = op_is_div(i_op);
  assign w_in_signed = op_is_signed(i_op);
  assign w_is_div    = op_is_div(r_op);
  assign w_accept    = (r_state == IDLE) && i_issue_valid && !i_flush;
  assign w_b_zero    = (i_b == '0);
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

  // Operand magnitudes at acceptance.
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs (
    .i_val    ({i_a, i_b}),
    .i_wide   (1'b0),
    .i_neg_hi (w_in_signed & i_a[WIDTH-1]),
    .i_neg_lo (w_in_signed & i_b[WIDTH-1]),
    .o_val    (w_abs)
  );
  assign w_abs_a = w_abs[2*WIDTH-1:WIDTH];
  assign w_abs_b = w_abs[WIDTH-1:0];

  // Shift-add multiply step.
  assign w_acc_mul = r_acc + (r_mq[0] ? r_mcand : '0);
  assign w_mq_mul  = r_mq >> 1;

  // Restoring divide step. The partial remainder never reaches 2^WIDTH after a subtraction,
  // so bit WIDTH of the difference is a clean borrow.
  assign w_rem_sh  = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_mcand[WIDTH-1:0]};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_mq_div  = {r_mq[WIDTH-2:0], w_ge};

  // Sign correction. A product is negated as one wide value. A divide has
  // hi = remainder and lo = quotient, which are negated separately.
  assign w_fix_in = w_is_div ? {r_acc[WIDTH-1:0], r_mq} : r_acc;
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .i_val    (w_fix_in),
    .i_wide   (!w_is_div),
    .i_neg_hi (w_is_div ? r_neg_r : r_neg_q),
    .i_neg_lo (r_neg_q),
    .o_val    (w_fixed)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_in_div && w_b_zero) w_state_nxt = DONE;
`ifdef MULDIV_EARLY_TERM_EN
          else if (!w_in_div && (w_abs_b == '0)) w_state_nxt = FIX;
`endif
          else w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_flush) w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = FIX;
`ifdef MULDIV_EARLY_TERM_EN
        else if (!w_is_div && (w_mq_mul == '0)) w_state_nxt = FIX;
`endif
      end
      FIX:     w_state_nxt = i_flush ? IDLE : DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, and load the corrected result.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mq    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div0  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= i_op;
            r_neg_q <= w_in_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r <= w_in_signed & i_a[WIDTH-1];
            r_cnt   <= '0;
            r_acc   <= '0;
            r_div0  <= 1'b0;
            if (w_in_div) begin
              r_mq    <= w_abs_a;
              r_mcand <= {{WIDTH{1'b0}}, w_abs_b};
              if (w_b_zero) begin
                r_hi   <= i_a;
                r_lo   <= '1;
                r_div0 <= 1'b1;
              end
            end else begin
              r_mq    <= w_abs_b;
              r_mcand <= {{WIDTH{1'b0}}, w_abs_a};
            end
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_is_div) begin
            r_acc <= {{WIDTH{1'b0}}, w_rem_nxt};
            r_mq  <= w_mq_div;
          end else begin
            r_acc   <= w_acc_mul;
            r_mq    <= w_mq_mul;
            r_mcand <= r_mcand << 1;
          end
        end
        FIX: begin
          if (!i_flush) {r_hi, r_lo} <= w_fixed;
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != IDLE);
  assign o_issue_ready = (r_state == IDLE);
  assign o_we_hilo     = (r_state == DONE);
  assign o_div0        = (r_state == DONE) && r_div0;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_stall_req   = o_busy && (i_hilo_rd_req || i_issue_valid);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer. It compares results against an arithmetic
// reference model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0, hilo_rd_req = 1'b0, flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        issue_ready, stall_req, we_hilo, div0, busy;
  logic [31:0] hi, lo;
  logic [31:0] last_hi = '0, last_lo = '0;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_issue_valid (issue_valid),
    .o_issue_ready (issue_ready),
    .i_op          (op),
    .i_a           (a),
    .i_b           (b),
    .i_hilo_rd_req (hilo_rd_req),
    .i_flush       (flush),
    .o_stall_req   (stall_req),
    .o_we_hilo     (we_hilo),
    .o_hi          (hi),
    .o_lo          (lo),
    .o_div0        (div0),
    .o_busy        (busy)
  );

  // Reference results from plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] mop, input logic [31:0] ma,
                                input logic [31:0] mb, output logic [31:0] eh,
                                output logic [31:0] el, output logic ed);
    longint          sa, sb, q, r;
    longint unsigned p;
    sa = {{32{ma[31]}}, ma};
    sb = {{32{mb[31]}}, mb};
    ed = 1'b0;
    eh = '0;
    el = '0;
    if (mop[1] && mb == 0) begin
      eh = ma; el = 32'hFFFF_FFFF; ed = 1'b1;
    end else begin
      case (mop)
        2'b00: begin p = {32'b0, ma} * {32'b0, mb}; {eh, el} = p; end
        2'b01: begin p = longint'(sa * sb); {eh, el} = p; end
        2'b10: begin el = ma / mb; eh = ma % mb; end
        default: begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      endcase
    end
  endfunction

  // Cycle of the write strobe, counting the acceptance cycle as 0.
  function automatic int exp_lat(input logic [1:0] mop, input logic [31:0] ma,
                                 input logic [31:0] mb);
    logic [31:0] mag;
    int          len;
    if (mop[1]) return (mb == 0) ? 1 : DONE_LAT;
    mag = (mop[0] && mb[31]) ? -mb : mb;
    len = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) len = i + 1;
`ifdef MULDIV_EARLY_TERM_EN
    return len + 2;
`else
    return (len >= 0) ? DONE_LAT : 0;
`endif
  endfunction

  task automatic do_op(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                       input string tag);
    logic [31:0] eh, el;
    logic        ed;
    int          lat, cyc;
    bit          seen;
    model(mop, ma, mb, eh, el, ed);
    lat = exp_lat(mop, ma, mb);
    op = mop; a = ma; b = mb; issue_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (issue_ready !== 1'b1 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: ready=%b stall=%b, want 1 0", tag, issue_ready, stall_req);
    end
    @(posedge clk); #1;
    issue_valid = 1'b0; a = $urandom; b = $urandom;
    cyc = 1; seen = 0;
    while (cyc < 60 && !seen) begin
      @(negedge clk);
      if (cyc == 1) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %b want 1", tag, busy); end
      end
      if (we_hilo === 1'b1) seen = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    n_checks++;
    if (!seen || cyc != lat) begin
      n_fail++;
      $display("FAIL %s latency: we_hilo seen=%0d cycle %0d, want cycle %0d", tag, seen, cyc, lat);
    end
    n_checks++;
    if (hi !== eh || lo !== el || div0 !== ed) begin
      n_fail++;
      $display("FAIL %s result: hi=%h lo=%h div0=%b, want %h %h %b", tag, hi, lo, div0, eh, el, ed);
    end
    last_hi = eh; last_lo = el;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (we_hilo !== 1'b0 || issue_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after: we=%b ready=%b busy=%b, want 0 1 0", tag, we_hilo, issue_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (we_hilo !== 0 || div0 !== 0 || hi !== 0 || lo !== 0 || stall_req !== 0 || busy !== 0 ||
        issue_ready !== 1) begin
      n_fail++;
      $display("FAIL reset: we=%b div0=%b hi=%h lo=%h stall=%b busy=%b ready=%b, want 0 0 0 0 0 0 1",
               we_hilo, div0, hi, lo, stall_req, busy, issue_ready);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    do_op(OP_MULT, -32'sd3, 32'd7, "mult_neg");
    do_op(OP_DIV, -32'sd7, 32'd2, "div_neg");
    do_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    do_op(OP_DIVU, 32'd5, 32'd0, "divu_zero");
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(OP_MULTU, 32'd5, 32'd3, "multu_5_3");
    do_op(OP_MULTU, 32'd1234, 32'd0, "multu_by_0");
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 255);
      do_op(rop, ra, rb, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eh, el, eh2, el2;
    logic        ed, ed2;
    logic [31:0] a2, b2;
    int          lat, cyc;
    bit          seen;
    a2 = $urandom; b2 = $urandom_range(1, 1000);
    model(OP_MULT, -32'sd3, 32'd7, eh, el, ed);
    model(OP_DIVU, a2, b2, eh2, el2, ed2);
    lat = exp_lat(OP_MULT, -32'sd3, 32'd7);
    op = OP_MULT; a = -32'sd3; b = 32'd7; issue_valid = 1'b1;
    @(posedge clk); #1;
    op = OP_DIVU; a = a2; b = b2;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      n_checks++;
      if (stall_req !== 1'b1 || we_hilo !== (c == lat)) begin
        n_fail++;
        $display("FAIL b2b cycle %0d: stall=%b we=%b, want 1 %b", c, stall_req, we_hilo, c == lat);
      end
      if (c == lat) begin
        n_checks++;
        if (hi !== eh || lo !== el) begin
          n_fail++;
          $display("FAIL b2b first result: hi=%h lo=%h, want %h %h", hi, lo, eh, el);
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (issue_ready !== 1'b1 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b accept: ready=%b stall=%b, want 1 0", issue_ready, stall_req);
    end
    @(posedge clk); #1;
    issue_valid = 1'b0;
    cyc = 1; seen = 0;
    while (cyc < 60 && !seen) begin
      @(negedge clk);
      if (we_hilo === 1'b1) seen = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    n_checks++;
    if (!seen || cyc != DONE_LAT || hi !== eh2 || lo !== el2) begin
      n_fail++;
      $display("FAIL b2b second: seen=%0d cyc=%0d hi=%h lo=%h, want cyc %0d %h %h",
               seen, cyc, hi, lo, DONE_LAT, eh2, el2);
    end
    last_hi = eh2; last_lo = el2;
    @(posedge clk); #1;
  endtask

  task automatic test_hilo_stall();
    bit want;
    op = OP_DIVU; a = 32'd1000; b = 32'd3; issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (c == 2) hilo_rd_req = 1'b1;
      @(negedge clk);
      want = (c >= 2 && c <= 34);
      n_checks++;
      if (stall_req !== want) begin
        n_fail++;
        $display("FAIL hilo_stall cycle %0d: stall=%b want %b", c, stall_req, want);
      end
      if (c == 34) begin
        n_checks++;
        if (we_hilo !== 1'b1 || lo !== 32'd333 || hi !== 32'd1) begin
          n_fail++;
          $display("FAIL hilo_stall write: we=%b hi=%h lo=%h, want 1 1 14d", we_hilo, hi, lo);
        end
      end
      @(posedge clk); #1;
    end
    hilo_rd_req = 1'b0;
    last_hi = 32'd1; last_lo = 32'd333;
  endtask

  task automatic test_flush();
    int nwe;
    op = OP_MULT; a = $urandom; b = 32'h7FFF_FFFF; issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (issue_ready !== 1'b1 || busy !== 1'b0 || hi !== last_hi || lo !== last_lo) begin
      n_fail++;
      $display("FAIL flush_run: ready=%b busy=%b hi=%h lo=%h, want 1 0 %h %h",
               issue_ready, busy, hi, lo, last_hi, last_lo);
    end
    nwe = 0;
    repeat (40) begin @(negedge clk); if (we_hilo === 1'b1) nwe++; end
    n_checks++;
    if (nwe != 0) begin n_fail++; $display("FAIL flush_run strobe: got %0d want 0", nwe); end
    @(posedge clk); #1;
    op = OP_MULTU; a = 32'd9; b = 32'd9; issue_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: busy=%b want 0", busy); end
    @(posedge clk); #1;
    op = OP_DIVU; a = 32'd5; b = 32'd0; issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (we_hilo !== 1'b1 || hi !== 32'd5 || lo !== 32'hFFFF_FFFF || div0 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done: we=%b hi=%h lo=%h div0=%b, want 1 5 ffffffff 1",
               we_hilo, hi, lo, div0);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    last_hi = 32'd5; last_lo = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset_mid();
    int nwe;
    op = OP_DIV; a = -32'sd1000; b = 32'd7; issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || we_hilo !== 1'b0 || hi !== 0 || lo !== 0 || issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b we=%b hi=%h lo=%h ready=%b, want 0 0 0 0 1",
               busy, we_hilo, hi, lo, issue_ready);
    end
    @(negedge clk); rst = 1'b1;
    nwe = 0;
    repeat (40) begin @(negedge clk); if (we_hilo === 1'b1) nwe++; end
    n_checks++;
    if (nwe != 0) begin n_fail++; $display("FAIL reset_mid strobe: got %0d want 0", nwe); end
    last_hi = '0; last_lo = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_hilo_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
